ann_load_seq_ctrl: RTL and testbench



---
 rtl/ann_load_seq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_ann_load_seq_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ann_load_seq_ctrl.sv
// Load/sequence controller for the ANN kd-tree accelerator: streams FIFO words into
// node, leaf and query memories, then hands off to the search core and result sender.
module ann_load_seq_ctrl #(
    parameter int DATA_WIDTH = 11,
    parameter int NUM_LEAVES = 64,
    parameter int NUM_QUERYS = 512
) (
    input  logic                  io_clk,
    input  logic                  io_rst_n,
    input  logic                  load_kdtree,
    input  logic                  fsm_start,
    input  logic                  send_best_arr,
    input  logic [DATA_WIDTH-1:0] in_fifo_rdata,
    input  logic                  in_fifo_rempty_n,
    output logic                  in_fifo_deq,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  node_wen,
    output logic [5:0]            node_addr,
    output logic                  node_sel,
    output logic                  leaf_wen,
    output logic [5:0]            leaf_addr,
    output logic [5:0]            leaf_word,
    output logic                  query_wen,
    output logic [8:0]            query_addr,
    output logic [2:0]            query_word,
    output logic                  core_start,
    output logic                  send_start,
    input  logic                  core_done,
    input  logic                  send_core_done,
    output logic                  load_done,
    output logic                  fsm_done,
    output logic                  send_done
);

    localparam int NUM_NODES   = NUM_LEAVES - 1;
    localparam int LEAF_WORDS  = 48;
    localparam int QUERY_WORDS = 5;

    typedef enum logic [2:0] {
        S_IDLE, S_LD_NODE, S_LD_LEAF, S_LD_QUERY, S_READY, S_RUN, S_SEND
    } state_t;

    state_t state, state_nxt;

    logic [5:0] node_cnt;
    logic       node_sel_cnt;
    logic [5:0] leaf_cnt;
    logic [5:0] leaf_word_cnt;
    logic [8:0] query_cnt;
    logic [2:0] query_word_cnt;

    logic loading;
    logic node_last, leaf_last, query_last;
    logic leaf_word_last, query_word_last;
    logic accept_load, accept_start, accept_send;

    assign loading     = (state == S_LD_NODE) || (state == S_LD_LEAF) || (state == S_LD_QUERY);
    assign in_fifo_deq = loading && in_fifo_rempty_n;

    assign leaf_word_last  = (leaf_word_cnt == 6'(LEAF_WORDS - 1));
    assign query_word_last = (query_word_cnt == 3'(QUERY_WORDS - 1));
    assign node_last       = (node_cnt == 6'(NUM_NODES - 1)) && node_sel_cnt;
    assign leaf_last       = (leaf_cnt == 6'(NUM_LEAVES - 1)) && leaf_word_last;
    assign query_last      = (query_cnt == 9'(NUM_QUERYS - 1)) && query_word_last;

    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) state <= S_IDLE;
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        else           state <= state_nxt;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_nxt    = state;
        accept_load  = 1'b0;
        accept_start = 1'b0;
        accept_send  = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_kdtree) begin
                    accept_load = 1'b1;
                    state_nxt   = S_LD_NODE;
                end
            end
            S_LD_NODE:  if (in_fifo_deq && node_last)  state_nxt = S_LD_LEAF;
            S_LD_LEAF:  if (in_fifo_deq && leaf_last)  state_nxt = S_LD_QUERY;
            S_LD_QUERY: if (in_fifo_deq && query_last) state_nxt = S_READY;
            S_READY: begin
                // Host commands are prioritised; the losers of a collision are dropped.
                if (load_kdtree) begin
                    accept_load = 1'b1;
                    state_nxt   = S_LD_NODE;
                end else if (fsm_start) begin
                    accept_start = 1'b1;
                    state_nxt    = S_RUN;
                end else if (send_best_arr && fsm_done) begin
                    accept_send = 1'b1;
                    state_nxt   = S_SEND;
                end
            end
            S_RUN:   if (core_done)      state_nxt = S_READY;
            S_SEND:  if (send_core_done) state_nxt = S_READY;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            wdata          <= '0;
            node_wen       <= 1'b0;
            node_addr      <= '0;
            node_sel       <= 1'b0;
            leaf_wen       <= 1'b0;
            leaf_addr      <= '0;
            leaf_word      <= '0;
            query_wen      <= 1'b0;
            query_addr     <= '0;
            query_word     <= '0;
            core_start     <= 1'b0;
            send_start     <= 1'b0;
            load_done      <= 1'b0;
            fsm_done       <= 1'b0;
            send_done      <= 1'b0;
            node_cnt       <= '0;
            node_sel_cnt   <= 1'b0;
            leaf_cnt       <= '0;
            leaf_word_cnt  <= '0;
            query_cnt      <= '0;
            query_word_cnt <= '0;
        end else begin
            node_wen   <= 1'b0;
            leaf_wen   <= 1'b0;
            query_wen  <= 1'b0;
            core_start <= accept_start;
            send_start <= accept_send;

            if (accept_load) begin
                node_cnt       <= '0;
                node_sel_cnt   <= 1'b0;
                leaf_cnt       <= '0;
                leaf_word_cnt  <= '0;
                query_cnt      <= '0;
                query_word_cnt <= '0;
                load_done      <= 1'b0;
                fsm_done       <= 1'b0;
                send_done      <= 1'b0;
            end
            if (accept_start)                      fsm_done  <= 1'b0;
            if (accept_send)                       send_done <= 1'b0;
            if (state == S_RUN && core_done)       fsm_done  <= 1'b1;
            if (state == S_SEND && send_core_done) send_done <= 1'b1;

            // One pop yields one strobe next cycle; counters wrap to 0 after their last word.
            if (in_fifo_deq) begin
                wdata <= in_fifo_rdata;
                case (state)
                    S_LD_NODE: begin
                        node_wen     <= 1'b1;
                        node_addr    <= node_cnt;
                        node_sel     <= node_sel_cnt;
                        node_sel_cnt <= ~node_sel_cnt;
                        if (node_sel_cnt) node_cnt <= node_last ? '0 : node_cnt + 6'd1;
                    end
                    S_LD_LEAF: begin
                        leaf_wen      <= 1'b1;
                        leaf_addr     <= leaf_cnt;
                        leaf_word     <= leaf_word_cnt;
                        leaf_word_cnt <= leaf_word_last ? '0 : leaf_word_cnt + 6'd1;
                        if (leaf_word_last) leaf_cnt <= leaf_last ? '0 : leaf_cnt + 6'd1;
                    end
                    S_LD_QUERY: begin
                        query_wen      <= 1'b1;
                        query_addr     <= query_cnt;
                        query_word     <= query_word_cnt;
                        query_word_cnt <= query_word_last ? '0 : query_word_cnt + 3'd1;
                        if (query_word_last) query_cnt <= query_last ? '0 : query_cnt + 9'd1;
                        if (query_last) load_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ann_load_seq_ctrl.sv
// Scoreboard bench for ann_load_seq_ctrl: predicted memory writes are queued at pop time
// and a negedge monitor compares each strobe the DUT presents against the queue head.
module tb_ann_load_seq_ctrl;

    localparam int DW = 13;  // wide enough that data = pop index never wraps
    localparam int TOTAL_WORDS = 5758;

    logic          io_clk = 1'b0;
    logic          io_rst_n = 1'b0;
    logic          load_kdtree = 1'b0, fsm_start = 1'b0, send_best_arr = 1'b0;
    logic [DW-1:0] in_fifo_rdata = '0;
    logic          in_fifo_rempty_n = 1'b0;
    logic          in_fifo_deq;
    logic [DW-1:0] wdata;
    logic          node_wen, node_sel, leaf_wen, query_wen;
    logic [5:0]    node_addr, leaf_addr, leaf_word;
    logic [8:0]    query_addr;
    logic [2:0]    query_word;
    logic          core_start, send_start;
    logic          core_done = 1'b0, send_core_done = 1'b0;
    logic          load_done, fsm_done, send_done;

    ann_load_seq_ctrl #(.DATA_WIDTH(DW), .NUM_LEAVES(64), .NUM_QUERYS(512)) dut (
        .io_clk(io_clk), .io_rst_n(io_rst_n),
        .load_kdtree(load_kdtree), .fsm_start(fsm_start), .send_best_arr(send_best_arr),
        .in_fifo_rdata(in_fifo_rdata), .in_fifo_rempty_n(in_fifo_rempty_n),
        .in_fifo_deq(in_fifo_deq), .wdata(wdata),
        .node_wen(node_wen), .node_addr(node_addr), .node_sel(node_sel),
        .leaf_wen(leaf_wen), .leaf_addr(leaf_addr), .leaf_word(leaf_word),
        .query_wen(query_wen), .query_addr(query_addr), .query_word(query_word),
        .core_start(core_start), .send_start(send_start),
        .core_done(core_done), .send_core_done(send_core_done),
        .load_done(load_done), .fsm_done(fsm_done), .send_done(send_done)
    );

    always #5 io_clk = ~io_clk;

    typedef struct packed {
        logic [1:0]    kind;  // 0 node, 1 leaf, 2 query
        logic [8:0]    addr;
        logic [5:0]    sub;   // sel / leaf word / query word
        logic [DW-1:0] data;
    } wr_t;

    wr_t sb_q[$];
    int  n_cmp = 0, n_bad = 0;
    int  strobes_since_load = 0;
    int  core_starts = 0, send_starts = 0;
    int  deq_while_empty = 0;
    logic load_done_q = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected write for the k-th pop of a load, laid out by hand from the memory map.
    function automatic wr_t model(input int k);
        wr_t e;
        int  j;
        e.data = DW'(k);
        if (k < 126) begin
            e.kind = 2'd0; e.addr = 9'(k / 2); e.sub = 6'(k % 2);
        end else if (k < 3198) begin
            j = k - 126;
            e.kind = 2'd1; e.addr = 9'(j / 48); e.sub = 6'(j % 48);
        end else begin
            j = k - 3198;
            e.kind = 2'd2; e.addr = 9'(j / 5); e.sub = 6'(j % 5);
        end
        return e;
    endfunction

    // Monitor: every strobe pops one expectation.
    wr_t act_w, exp_w;
    int  n_wen;
    always @(negedge io_clk) begin
        n_wen = int'(node_wen) + int'(leaf_wen) + int'(query_wen);
        if (n_wen > 1) check("one_strobe", n_wen, 1);
        if (n_wen == 1) begin
            strobes_since_load++;
            act_w.kind = leaf_wen ? 2'd1 : (query_wen ? 2'd2 : 2'd0);
            act_w.addr = node_wen ? 9'(node_addr) : (leaf_wen ? 9'(leaf_addr) : query_addr);
            act_w.sub  = node_wen ? 6'(node_sel) : (leaf_wen ? leaf_word : 6'(query_word));
            act_w.data = wdata;
            if (sb_q.size() == 0) begin
                check("sb_unexpected_strobe", sb_q.size(), 1);
            end else begin
                exp_w = sb_q.pop_front();
                check("write", act_w, exp_w);
            end
        end
        if (core_start) core_starts++;
        if (send_start) send_starts++;
        if (load_done && !load_done_q) check("load_done_strobes", strobes_since_load, TOTAL_WORDS);
        load_done_q = load_done;
    end

    task automatic cmd(input logic l, input logic f, input logic s);
        @(negedge io_clk);
        if (l) strobes_since_load = 0;
        load_kdtree = l; fsm_start = f; send_best_arr = s;
        @(negedge io_clk);
        load_kdtree = 1'b0; fsm_start = 1'b0; send_best_arr = 1'b0;
    endtask

    task automatic pulse_done(input bit which_send);
        @(negedge io_clk);
        if (which_send) send_core_done = 1'b1; else core_done = 1'b1;
        @(negedge io_clk);
        send_core_done = 1'b0; core_done = 1'b0;
    endtask

    // Feed words 0..stop_after-1; gappy empties the FIFO every other cycle.
    task automatic run_load(input int stop_after, input bit gappy);
        int idx = 0;
        int cyc = 0;
        deq_while_empty = 0;
        while (idx < stop_after && cyc < 20000) begin
            @(negedge io_clk);
            cyc++;
            in_fifo_rdata    = DW'(idx);
            in_fifo_rempty_n = gappy ? cyc[0] : 1'b1;
            #1;
            if (!in_fifo_rempty_n && in_fifo_deq) deq_while_empty++;
            if (in_fifo_deq) begin
                sb_q.push_back(model(idx));
                idx++;
            end
        end
        @(negedge io_clk);
        in_fifo_rempty_n = 1'b0;
        check("load_words_popped", idx, stop_after);
        check("deq_when_empty", deq_while_empty, 0);
    endtask

    task automatic wait_load_done();
        int c = 0;
        while (!load_done && c < 200) begin
            @(negedge io_clk);
            c++;
        end
        check("load_done", load_done, 1);
        repeat (3) @(negedge io_clk);
        check("sb_drained", sb_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge io_clk);
        check("rst_wdata", wdata, 0);
        check("rst_strobes", {node_wen, leaf_wen, query_wen, core_start, send_start, in_fifo_deq}, 0);
        check("rst_flags", {load_done, fsm_done, send_done}, 0);
        check("rst_addrs", {node_addr, node_sel, leaf_addr, leaf_word, query_addr, query_word}, 0);
        io_rst_n = 1'b1;

        // Commands and completions outside their accepting state are ignored.
        cmd(1'b0, 1'b1, 1'b0);
        cmd(1'b0, 1'b0, 1'b1);
        pulse_done(1'b0);
        repeat (3) @(negedge io_clk);
        check("idle_no_core_start", core_starts, 0);
        check("idle_no_send_start", send_starts, 0);
        check("idle_flags", {load_done, fsm_done, send_done}, 0);

        // Full load, FIFO never empty.
        cmd(1'b1, 1'b0, 1'b0);
        run_load(TOTAL_WORDS, 1'b0);
        wait_load_done();

        cmd(1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge io_clk);
        check("send_before_fsm_done", send_starts, 0);

        cmd(1'b0, 1'b1, 1'b0);
        cmd(1'b0, 1'b1, 1'b0);  // RUN: second start must be ignored
        pulse_done(1'b1);       // stray send completion in RUN
        repeat (2) @(negedge io_clk);
        check("core_start_once", core_starts, 1);
        check("run_flags", {fsm_done, send_done}, 2'b00);
        pulse_done(1'b0);
        @(negedge io_clk);
        check("fsm_done_set", fsm_done, 1);

        cmd(1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge io_clk);
        check("send_start_once", send_starts, 1);
        check("send_done_pending", send_done, 0);
        pulse_done(1'b1);
        @(negedge io_clk);
        check("send_done_set", send_done, 1);

        // Load wins over start in the same cycle; then a gappy load.
        cmd(1'b1, 1'b1, 1'b0);
        check("collide_flags", {load_done, fsm_done, send_done}, 0);
        run_load(TOTAL_WORDS, 1'b1);
        wait_load_done();
        check("collide_no_core_start", core_starts, 1);

        // Abandon a load at leaf 10 word 20 with an asynchronous reset.
        cmd(1'b1, 1'b0, 1'b0);
        run_load(126 + 10 * 48 + 21, 1'b0);
        repeat (3) @(negedge io_clk);
        check("mid_sb_drained", sb_q.size(), 0);
        check("mid_position", {leaf_addr, leaf_word}, {6'd10, 6'd20});
        @(posedge io_clk);
        #2 io_rst_n = 1'b0;
        #1;
        check("async_rst_wdata", wdata, 0);
        check("async_rst_addrs", {leaf_addr, leaf_word, node_addr, query_addr}, 0);
        check("async_rst_ctrl", {leaf_wen, in_fifo_deq, load_done, fsm_done, send_done}, 0);
        @(negedge io_clk);
        io_rst_n = 1'b1;

        cmd(1'b1, 1'b0, 1'b0);
        run_load(TOTAL_WORDS, 1'b0);
        wait_load_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
